// File: rtl/avalon_mm_ram_pkg.sv
// Shared types and helpers for the Avalon-MM burst RAM slave.
package avalon_mm_ram_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRdBurst,
    StWrBurst
  } state_e;

  // Number of byte-offset bits inside one data word.
  function automatic int unsigned byte_off_w(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/avalon_mm_ram_bytewrite.sv
// Simple dual-port RAM: per-byte write enables, one-cycle registered read.
module avalon_mm_ram_bytewrite #(
  parameter int unsigned DATA_W     = 256,
  parameter int unsigned DEPTH_LOG2 = 12
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   be,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [DATA_W-1:0]     rdata
);

  localparam int unsigned NB = DATA_W / 8;

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clock) begin
    if (we) begin
      for (int k = 0; k < NB; k++) begin
        if (be[k]) mem[waddr][k*8 +: 8] <= wdata[k*8 +: 8];
      end
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/avalon_mm_burst_ram_slave.sv
// Avalon-MM burst slave backed by an internal RAM, with optional periodic
// waitrequest stalls to exercise master backpressure.
module avalon_mm_burst_ram_slave
  import avalon_mm_ram_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 256,
  parameter int unsigned BURST_W      = 5,
  parameter int unsigned DEPTH_LOG2   = 12,
  parameter int unsigned STALL_PERIOD = 0
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic [ADDR_W-1:0]   avs_address,
  input  logic                avs_read,
  input  logic                avs_write,
  input  logic [BURST_W-1:0]  avs_burstcount,
  input  logic [DATA_W-1:0]   avs_writedata,
  input  logic [DATA_W/8-1:0] avs_byteenable,
  output logic                avs_waitrequest,
  output logic [DATA_W-1:0]   avs_readdata,
  output logic                avs_readdatavalid,
  output logic                avs_writeack,
  output logic                protocol_err
);

  localparam int unsigned OFF_W     = byte_off_w(DATA_W);
  localparam int unsigned MAX_BURST = 2**(BURST_W-1);
  localparam int unsigned CNT_W     = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
  localparam logic [CNT_W-1:0] STALL_LAST =
      CNT_W'((STALL_PERIOD == 0) ? 0 : STALL_PERIOD - 1);

  state_e                state_q;
  logic                  active_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [BURST_W-1:0]    rem_q;
  logic                  wack_q;
  logic                  err_q;
  logic [CNT_W-1:0]      stall_cnt_q;
  logic                  rd_pipe_q;
  logic                  rdv_q;
  logic [DATA_W-1:0]     readdata_q;

  logic                  stall;
  logic                  accept;
  logic [DEPTH_LOG2-1:0] cmd_idx;
  logic                  burst_bad;
  logic [BURST_W-1:0]    burst_len;
  logic                  ram_we;
  logic                  ram_re;
  logic [DEPTH_LOG2-1:0] ram_addr;
  logic [DATA_W-1:0]     ram_rdata;
  logic                  unused_addr;

  // Misaligned low bits and bits above the RAM depth are deliberately dropped.
  assign unused_addr = ^avs_address;
  assign cmd_idx     = avs_address[OFF_W +: DEPTH_LOG2];

  always_comb begin
    burst_bad = (avs_burstcount == '0) || (avs_burstcount > BURST_W'(MAX_BURST));
    burst_len = burst_bad ? BURST_W'(1) : avs_burstcount;
  end

  assign stall = (STALL_PERIOD != 0) && (stall_cnt_q == STALL_LAST);

  // Held high until the first edge after reset release; a read during a
  // write burst is refused so only write beats get through.
  always_comb begin
    avs_waitrequest = !active_q || stall;
    if (state_q == StRdBurst) avs_waitrequest = 1'b1;
    if (state_q == StWrBurst && avs_read && !avs_write) avs_waitrequest = 1'b1;
  end

  assign accept = (avs_read || avs_write) && !avs_waitrequest;

  always_comb begin
    ram_we   = 1'b0;
    ram_re   = 1'b0;
    ram_addr = idx_q;
    unique case (state_q)
      StIdle: begin
        ram_addr = cmd_idx;
        if (accept) begin
          ram_we = avs_write;
          ram_re = !avs_write;
        end
      end
      StRdBurst: ram_re = !stall;
      StWrBurst: ram_we = accept && avs_write;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stall_cnt_q <= '0;
    end else if (STALL_PERIOD != 0) begin
      stall_cnt_q <= (stall_cnt_q == STALL_LAST) ? '0 : stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      active_q <= 1'b0;
      idx_q    <= '0;
      rem_q    <= '0;
      wack_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      active_q <= 1'b1;
      wack_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            if (burst_bad || (avs_read && avs_write)) err_q <= 1'b1;
            idx_q <= cmd_idx + DEPTH_LOG2'(1);
            rem_q <= burst_len - BURST_W'(1);
            if (burst_len == BURST_W'(1)) begin
              wack_q <= avs_write;
            end else begin
              state_q <= avs_write ? StWrBurst : StRdBurst;
            end
          end
        end
        StRdBurst: begin
          if (!stall) begin
            idx_q <= idx_q + DEPTH_LOG2'(1);
            rem_q <= rem_q - BURST_W'(1);
            if (rem_q == BURST_W'(1)) state_q <= StIdle;
          end
        end
        StWrBurst: begin
          if (accept) begin
            idx_q <= idx_q + DEPTH_LOG2'(1);
            rem_q <= rem_q - BURST_W'(1);
            if (rem_q == BURST_W'(1)) begin
              wack_q  <= 1'b1;
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // RAM read register plus this output register give the two-cycle latency.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rd_pipe_q  <= 1'b0;
      rdv_q      <= 1'b0;
      readdata_q <= '0;
    end else begin
      rd_pipe_q <= ram_re;
      rdv_q     <= rd_pipe_q;
      if (rd_pipe_q) readdata_q <= ram_rdata;
    end
  end

  avalon_mm_ram_bytewrite #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clock (clock),
    .we    (ram_we),
    .waddr (ram_addr),
    .wdata (avs_writedata),
    .be    (avs_byteenable),
    .re    (ram_re),
    .raddr (ram_addr),
    .rdata (ram_rdata)
  );

  assign avs_readdata      = readdata_q;
  assign avs_readdatavalid = rdv_q;
  assign avs_writeack      = wack_q;
  assign protocol_err      = err_q;

endmodule

// File: tb/tb_avalon_mm_burst_ram_slave.sv
// Directed bench: instance 0 plain, instance 1 with stalls every 4 cycles,
// instance 2 with a 16-word RAM for wrap-around.
module tb_avalon_mm_burst_ram_slave;

  localparam int AW = 32;
  localparam int DW = 256;
  localparam int BW = 5;
  localparam int NB = DW / 8;

  typedef struct {
    int            t;
    logic [DW-1:0] data;
  } rv_t;

  logic clock = 1'b0;
  logic resetn;
  int   cyc = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  logic [AW-1:0] addr  [3];
  logic          rd    [3];
  logic          wr    [3];
  logic [BW-1:0] bc    [3];
  logic [DW-1:0] wdata [3];
  logic [NB-1:0] be    [3];

  logic          wreq0, wreq1, wreq2, rdv0, rdv1, rdv2;
  logic          wack0, wack1, wack2, perr0, perr1, perr2;
  logic [DW-1:0] rdata0, rdata1, rdata2;

  logic          wreq_a  [3];
  logic          rdv_a   [3];
  logic          wack_a  [3];
  logic          perr_a  [3];
  logic [DW-1:0] rdata_a [3];

  always_comb begin
    wreq_a[0] = wreq0;  wreq_a[1] = wreq1;  wreq_a[2] = wreq2;
    rdv_a[0]  = rdv0;   rdv_a[1]  = rdv1;   rdv_a[2]  = rdv2;
    wack_a[0] = wack0;  wack_a[1] = wack1;  wack_a[2] = wack2;
    perr_a[0] = perr0;  perr_a[1] = perr1;  perr_a[2] = perr2;
    rdata_a[0] = rdata0; rdata_a[1] = rdata1; rdata_a[2] = rdata2;
  end

  avalon_mm_burst_ram_slave #(
    .ADDR_W(AW), .DATA_W(DW), .BURST_W(BW), .DEPTH_LOG2(12), .STALL_PERIOD(0)
  ) u_dut0 (
    .clock(clock), .resetn(resetn), .avs_address(addr[0]), .avs_read(rd[0]),
    .avs_write(wr[0]), .avs_burstcount(bc[0]), .avs_writedata(wdata[0]),
    .avs_byteenable(be[0]), .avs_waitrequest(wreq0), .avs_readdata(rdata0),
    .avs_readdatavalid(rdv0), .avs_writeack(wack0), .protocol_err(perr0)
  );

  avalon_mm_burst_ram_slave #(
    .ADDR_W(AW), .DATA_W(DW), .BURST_W(BW), .DEPTH_LOG2(12), .STALL_PERIOD(4)
  ) u_dut1 (
    .clock(clock), .resetn(resetn), .avs_address(addr[1]), .avs_read(rd[1]),
    .avs_write(wr[1]), .avs_burstcount(bc[1]), .avs_writedata(wdata[1]),
    .avs_byteenable(be[1]), .avs_waitrequest(wreq1), .avs_readdata(rdata1),
    .avs_readdatavalid(rdv1), .avs_writeack(wack1), .protocol_err(perr1)
  );

  avalon_mm_burst_ram_slave #(
    .ADDR_W(AW), .DATA_W(DW), .BURST_W(BW), .DEPTH_LOG2(4), .STALL_PERIOD(0)
  ) u_dut2 (
    .clock(clock), .resetn(resetn), .avs_address(addr[2]), .avs_read(rd[2]),
    .avs_write(wr[2]), .avs_burstcount(bc[2]), .avs_writedata(wdata[2]),
    .avs_byteenable(be[2]), .avs_waitrequest(wreq2), .avs_readdata(rdata2),
    .avs_readdatavalid(rdv2), .avs_writeack(wack2), .protocol_err(perr2)
  );

  // Only one instance is exercised at a time, so one log covers all three.
  rv_t rv_q [$];
  int  wk_q [$];

  always @(negedge clock) begin : mon
    rv_t e;
    for (int d = 0; d < 3; d++) begin
      if (rdv_a[d]) begin
        e.t    = cyc;
        e.data = rdata_a[d];
        rv_q.push_back(e);
      end
      if (wack_a[d]) wk_q.push_back(cyc);
    end
  end

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [DW-1:0] got,
                          input logic [DW-1:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge with t = cycle the beat was accepted in.
  task automatic beat(input int d, input bit r, input bit w, input logic [AW-1:0] a,
                      input logic [BW-1:0] n, input logic [DW-1:0] dat,
                      input logic [NB-1:0] e, output int t);
    bit done;
    done = 1'b0;
    t = -1;
    rd[d] = r; wr[d] = w; addr[d] = a; bc[d] = n; wdata[d] = dat; be[d] = e;
    for (int g = 0; g < 40 && !done; g++) begin
      #1;
      if (!wreq_a[d]) begin
        done = 1'b1;
        t = cyc;
      end
      @(negedge clock);
    end
    if (!done) check_eq("accept_timeout", 0, 1);
  endtask

  task automatic idle(input int d);
    rd[d] = 1'b0;
    wr[d] = 1'b0;
  endtask

  task automatic clear_logs();
    rv_q.delete();
    wk_q.delete();
  endtask

  initial begin
    int            t, t0, phase, nhigh, first_hi, c;
    int            exp_t [8];
    logic [DW-1:0] exp_v;

    resetn = 1'b0;
    for (int d = 0; d < 3; d++) begin
      idle(d); addr[d] = '0; bc[d] = 1; wdata[d] = '0; be[d] = '1;
    end
    repeat (3) @(negedge clock);
    check_eq("rst_wreq",  wreq_a[0], 1);
    check_eq("rst_rdv",   rdv_a[0],  0);
    check_eq("rst_rdata", rdata_a[0], 0);
    check_eq("rst_wack",  wack_a[0], 0);
    check_eq("rst_perr",  perr_a[0], 0);
    resetn = 1'b1;
    repeat (2) @(negedge clock);
    check_eq("idle_wreq", wreq_a[0], 0);

    // Single write then single read of 0x20.
    clear_logs();
    beat(0, 0, 1, 32'h20, 1, {32{8'hA5}}, '1, t);
    idle(0);
    repeat (3) @(negedge clock);
    check_eq("t1_wack_n", wk_q.size(), 1);
    if (wk_q.size() > 0) check_eq("t1_wack_t", wk_q[0], t + 1);
    beat(0, 1, 0, 32'h20, 1, '0, '0, t);
    idle(0);
    repeat (4) @(negedge clock);
    check_eq("t1_rv_n", rv_q.size(), 1);
    if (rv_q.size() > 0) begin
      check_eq("t1_rv_t", rv_q[0].t, t + 2);
      check_eq("t1_rv_d", rv_q[0].data, {32{8'hA5}});
    end

    // 16-beat write burst; later beats carry junk address/burstcount.
    clear_logs();
    for (int i = 0; i < 16; i++)
      beat(0, 0, 1, (i == 0) ? 32'h0040_0000 : 32'hDEAD_0000, (i == 0) ? 5'd16 : 5'd3,
           DW'(i), '1, t);
    idle(0);
    repeat (3) @(negedge clock);
    check_eq("t2_wack_n", wk_q.size(), 1);
    if (wk_q.size() > 0) check_eq("t2_wack_t", wk_q[0], t + 1);
    beat(0, 1, 0, 32'h0040_0000, 16, '0, '0, t0);
    idle(0);
    repeat (20) @(negedge clock);
    check_eq("t2_rv_n", rv_q.size(), 16);
    for (int k = 0; k < 16 && k < rv_q.size(); k++) begin
      check_eq($sformatf("t2_rv_d%0d", k), rv_q[k].data, DW'(k));
      check_eq($sformatf("t2_rv_t%0d", k), rv_q[k].t, t0 + 2 + k);
    end

    // Byte enables, with the read issued right after the partial write.
    clear_logs();
    beat(0, 0, 1, 32'h100, 1, {32{8'hFF}}, '1, t);
    beat(0, 0, 1, 32'h100, 1, '0, 32'h0000_000F, t);
    beat(0, 1, 0, 32'h100, 1, '0, '0, t0);
    idle(0);
    check_eq("t3_raw_gap", t0, t + 1);
    repeat (4) @(negedge clock);
    exp_v = {{28{8'hFF}}, 32'h0};
    check_eq("t3_rv_n", rv_q.size(), 1);
    if (rv_q.size() > 0) check_eq("t3_rv_d", rv_q[0].data, exp_v);

    // burstcount = 0 acts as a single beat and flags an error.
    clear_logs();
    check_eq("t4_perr_pre", perr_a[0], 0);
    beat(0, 1, 0, 32'h100, 0, '0, '0, t);
    idle(0);
    repeat (5) @(negedge clock);
    check_eq("t4_rv_n", rv_q.size(), 1);
    if (rv_q.size() > 0) check_eq("t4_rv_d", rv_q[0].data, exp_v);
    check_eq("t4_perr", perr_a[0], 1);

    // Stalled instance: fill 8 words, find the stall phase, then read back.
    clear_logs();
    for (int i = 0; i < 8; i++) beat(1, 0, 1, 32'h0, 8, DW'(100 + i), '1, t);
    idle(1);
    repeat (3) @(negedge clock);
    check_eq("t5_wack_n", wk_q.size(), 1);
    nhigh = 0;
    first_hi = -1;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (wreq_a[1]) begin
        nhigh++;
        if (first_hi < 0) first_hi = cyc;
      end
      @(negedge clock);
    end
    check_eq("t5_stall_n", nhigh, 2);
    phase = (first_hi < 0) ? 0 : first_hi % 4;
    beat(1, 1, 0, 32'h0, 8, '0, '0, t0);
    idle(1);
    c = t0;
    for (int k = 0; k < 8; k++) begin
      exp_t[k] = c;
      c++;
      while (c % 4 == phase) c++;
    end
    repeat (20) @(negedge clock);
    check_eq("t5_rv_n", rv_q.size(), 8);
    for (int k = 0; k < 8 && k < rv_q.size(); k++) begin
      check_eq($sformatf("t5_rv_d%0d", k), rv_q[k].data, DW'(100 + k));
      check_eq($sformatf("t5_rv_t%0d", k), rv_q[k].t, exp_t[k] + 2);
    end
    if (rv_q.size() == 8) check_eq("t5_gaps", (rv_q[7].t - rv_q[0].t) > 7, 1);

    // 16-word RAM: words 14,15,0,1; 0x200 aliases word 0, 0x1C5 is misaligned.
    clear_logs();
    beat(2, 0, 1, 32'h1C0, 1, DW'(14), '1, t);
    beat(2, 0, 1, 32'h1E0, 1, DW'(15), '1, t);
    beat(2, 0, 1, 32'h200, 1, DW'(256), '1, t);
    beat(2, 0, 1, 32'h020, 1, DW'(257), '1, t);
    beat(2, 1, 0, 32'h1C5, 4, '0, '0, t0);
    idle(2);
    repeat (8) @(negedge clock);
    check_eq("t6_rv_n", rv_q.size(), 4);
    if (rv_q.size() == 4) begin
      check_eq("t6_w14", rv_q[0].data, DW'(14));
      check_eq("t6_w15", rv_q[1].data, DW'(15));
      check_eq("t6_w0",  rv_q[2].data, DW'(256));
      check_eq("t6_w1",  rv_q[3].data, DW'(257));
    end

    // Reset during the third beat of an 8-beat read.
    clear_logs();
    check_eq("t7_perr_pre", perr_a[0], 1);
    beat(0, 1, 0, 32'h0040_0000, 8, '0, '0, t);
    idle(0);
    repeat (3) @(negedge clock);
    check_eq("t7_rdv_pre", rdv_a[0], 1);
    check_eq("t7_d_pre", rdata_a[0], DW'(2));
    resetn = 1'b0;
    #1;
    check_eq("t7_rdv_drop", rdv_a[0], 0);
    check_eq("t7_perr_clr", perr_a[0], 0);
    check_eq("t7_wreq_rst", wreq_a[0], 1);
    clear_logs();
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check_eq("t7_wreq_hold", wreq_a[0], 1);
      check_eq("t7_rdv_hold", rdv_a[0], 0);
    end
    resetn = 1'b1;
    #1;
    check_eq("t7_wreq_rel", wreq_a[0], 1);
    @(negedge clock);
    #1;
    check_eq("t7_wreq_after", wreq_a[0], 0);
    repeat (10) @(negedge clock);
    check_eq("t7_no_rv", rv_q.size(), 0);
    check_eq("t7_no_wack", wk_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/avalon_mm_burst_ram_slave.md
Name: avalon_mm_burst_ram_slave

Overview:
Synthesizable Avalon-MM burst slave with internal RAM. It is the responder for the kernel global-memory master port (avm_memgmem0_port_0_0_rw_*), and it replaces the Qsys on-chip RAM in kernel simulation. It serves pipelined burst reads and burst writes and generates writeack. It can inject periodic waitrequest stalls to exercise LSU backpressure.

Parameters:
- ADDR_W, 32, byte address width
- DATA_W, 256, data width in bits; must be a power of two and ≥ 8
- BURST_W, 5, burstcount width; maximum legal burst is MAX_BURST = 2^(BURST_W-1) = 16
- DEPTH_LOG2, 12, RAM depth is 2^DEPTH_LOG2 words of DATA_W bits
- STALL_PERIOD, 0, 0 disables stalls; P>0 forces waitrequest high 1 cycle in every P

Ports:
- clock  in  1  single clock
- resetn  in  1  asynchronous, active-low reset
- avs_address  in  ADDR_W  byte address of the first beat
- avs_read  in  1  read request
- avs_write  in  1  write request
- avs_burstcount  in  BURST_W  beats in burst; sampled on the first beat only
- avs_writedata  in  DATA_W  write data
- avs_byteenable  in  DATA_W/8  byte enables, applied per beat
- avs_waitrequest  out  1  command/beat not accepted this cycle
- avs_readdata  out  DATA_W  read data
- avs_readdatavalid  out  1  readdata valid, one pulse per read beat
- avs_writeack  out  1  1-cycle pulse after the last beat of a write burst is accepted
- protocol_err  out  1  sticky error flag

Behaviour:
- Reset values: waitrequest=1, readdatavalid=0, readdata=0, writeack=0, protocol_err=0; state=IDLE. RAM contents are not reset.
- Word index = avs_address[ADDR_W-1 : log2(DATA_W/8)] truncated to DEPTH_LOG2 bits. Low (misaligned) address bits are ignored. Word index increments per beat and wraps modulo 2^DEPTH_LOG2.
- Stall: a free-running counter 0..P-1 forces waitrequest=1 when it equals P-1. During a stall cycle no beat is accepted and no read beat is issued.
- Accept rule: a beat is accepted when (read|write) && !waitrequest.
- States:
  - IDLE: waitrequest=0 unless stalled. If both read and write are asserted, write wins and protocol_err is set.
    - Read accepted: latch index and count; go to RD_BURST.
    - Write accepted: write beat 0. If count=1, stay in IDLE and pulse writeack; otherwise go to WR_BURST with remaining=count-1.
  - RD_BURST: waitrequest=1. Issues one RAM read per non-stall cycle, with beat 0 issued in the accept cycle. After the last beat is issued, returns to IDLE, so a new command can be accepted the next cycle.
  - WR_BURST: waitrequest=0 unless stalled. Only write beats are accepted; a read request stalls. burstcount and address on later beats are ignored. After the last beat, pulse writeack and go to IDLE.
- Read latency: readdatavalid for a beat issued at cycle t asserts at t+2 (synchronous RAM plus output register). An unstalled burst returns back-to-back beats in order. Stalls create gaps in readdatavalid.
- Writeack timing: asserts the cycle after the last write beat is accepted.
- Byte lanes: byte k is written only when byteenable[k]=1.
- Read-after-write: a read accepted the cycle after a write to the same word returns the new data.
- burstcount=0 or burstcount>MAX_BURST: treated as 1 and sets protocol_err. protocol_err clears only on reset.
- Reset mid-burst: the burst is aborted, in-flight readdatavalid pulses are dropped and any pending writeack is cancelled.

Decomposition:
- Package avalon_mm_ram_pkg holds:
  - the state enum (IDLE, RD_BURST, WR_BURST)
  - the localparam function for byte-offset width, log2(DATA_W/8)
- One sub-module, avalon_mm_ram_bytewrite: simple dual-port RAM with per-byte write enable and 1-cycle registered read.

Test Plan:
- Reset, then a single write to addr 0x20 with data 0xA5… and be=all-ones, then a single read of 0x20 -> writeack pulses 1 cycle after the write is accepted; readdatavalid 2 cycles after read accept with data 0xA5….
- Write burst of 16 beats at 0x400000 with data = beat index, then read burst of 16 -> writeack occurs once, after beat 16; exactly 16 consecutive readdatavalid pulses with data 0..15.
- Byte-enable: write 0xFF… with be=all-ones, then 0x00… with be=0x0000000F, then read -> low 4 bytes are 0x00 and the remaining bytes are 0xFF.
- STALL_PERIOD=4, read burst of 8 -> waitrequest high in every 4th cycle; 8 readdatavalid pulses with gaps; data order preserved.
- Wrap: with DEPTH_LOG2=4, a read burst of 4 starting at word 14 -> beats return words 14, 15, 0, 1.
- Error/reset: burstcount=0 -> one beat and protocol_err=1. Then resetn low during the 3rd beat of an 8-beat read -> readdatavalid drops immediately, protocol_err clears, waitrequest stays high until reset is released.
